bottle_fill_ctrl: RTL and testbench

//  Upstream controller of the bottling line's alarm stage. Counts pills from the pill-drop

---
 rtl/bottle_fill_ctrl.sv | 147 ++++++++++++++
 tb/tb_bottle_fill_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bottle_fill_ctrl.sv
// Pill/bottle batch sequencer feeding the alarm stage; allFull is high once the batch target is met.
// Optional SPILL_CNT_EN macro builds a saturating counter of pills seen outside FILL.
module bottle_fill_ctrl #(
  parameter int CNT_W       = 8,
  parameter int SWAP_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             CLEAR,
  input  logic             PAUSE,
  input  logic             PILL,
  input  logic [CNT_W-1:0] PER_BOTTLE,
  input  logic [CNT_W-1:0] BOTTLE_TARGET,
  output logic [CNT_W-1:0] PILL_CNT,
  output logic [CNT_W-1:0] BOTTLE_CNT,
  output logic             BOTTLE_DONE,
  output logic             BUSY,
  output logic             allFull,
  output logic [CNT_W-1:0] SPILL_CNT
);

  typedef enum logic [1:0] {IDLE, FILL, SWAP, FULL} state_t;

  localparam int TMR_W = $clog2(SWAP_CYCLES + 1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] per_bottle_q, per_bottle_nxt;
  logic [CNT_W-1:0] bottle_target_q, bottle_target_nxt;
  logic [CNT_W-1:0] pill_cnt_nxt, bottle_cnt_nxt;
  logic [TMR_W-1:0] timer_q, timer_nxt;
  logic             done_nxt;
  logic             pill_p0, pill_p1, pill_p2, pill_evt;

  // Stage p0/p1 resynchronise the raw sensor; p2 and pill_evt form a registered rising-edge detect.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pill_p0  <= 1'b0;
      pill_p1  <= 1'b0;
      pill_p2  <= 1'b0;
      pill_evt <= 1'b0;
    end else begin
      pill_p0  <= PILL;
      pill_p1  <= pill_p0;
      pill_p2  <= pill_p1;
      pill_evt <= pill_p1 & ~pill_p2;
    end
  end

  always_comb begin
    state_nxt         = state_q;
    per_bottle_nxt    = per_bottle_q;
    bottle_target_nxt = bottle_target_q;
    pill_cnt_nxt      = PILL_CNT;
    bottle_cnt_nxt    = BOTTLE_CNT;
    timer_nxt         = timer_q;
    done_nxt          = 1'b0;
    if (CLEAR) begin
      state_nxt      = IDLE;
      pill_cnt_nxt   = '0;
      bottle_cnt_nxt = '0;
      timer_nxt      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START && (PER_BOTTLE != '0) && (BOTTLE_TARGET != '0)) begin
            per_bottle_nxt    = PER_BOTTLE;
            bottle_target_nxt = BOTTLE_TARGET;
            pill_cnt_nxt      = '0;
            bottle_cnt_nxt    = '0;
            state_nxt         = FILL;
          end
        end
        FILL: begin
          if (pill_evt) begin
            if ((PILL_CNT + CNT_W'(1)) != per_bottle_q) begin
              pill_cnt_nxt = PILL_CNT + CNT_W'(1);
            end else begin
              pill_cnt_nxt   = '0;
              bottle_cnt_nxt = BOTTLE_CNT + CNT_W'(1);
              done_nxt       = 1'b1;
              if ((BOTTLE_CNT + CNT_W'(1)) == bottle_target_q) begin
                state_nxt = FULL;
              end else begin
                state_nxt = SWAP;
                timer_nxt = TMR_W'(SWAP_CYCLES);
              end
            end
          end
        end
        SWAP: begin
          // The edge that takes the timer to zero is also the edge back into FILL.
          if (!PAUSE) begin
            if (timer_q <= TMR_W'(1)) begin
              timer_nxt = '0;
              state_nxt = FILL;
            end else begin
              timer_nxt = timer_q - TMR_W'(1);
            end
          end
        end
        FULL:    state_nxt = FULL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // BUSY/allFull are registered from the next state so they track state_q exactly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q         <= IDLE;
      per_bottle_q    <= '0;
      bottle_target_q <= '0;
      timer_q         <= '0;
      PILL_CNT        <= '0;
      BOTTLE_CNT      <= '0;
      BOTTLE_DONE     <= 1'b0;
      BUSY            <= 1'b0;
      allFull         <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      per_bottle_q    <= per_bottle_nxt;
      bottle_target_q <= bottle_target_nxt;
      timer_q         <= timer_nxt;
      PILL_CNT        <= pill_cnt_nxt;
      BOTTLE_CNT      <= bottle_cnt_nxt;
      BOTTLE_DONE     <= done_nxt;
      BUSY            <= (state_nxt == FILL) || (state_nxt == SWAP);
      allFull         <= (state_nxt == FULL);
    end
  end

`ifdef SPILL_CNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SPILL_CNT <= '0;
    end else if (CLEAR) begin
      SPILL_CNT <= '0;
    end else if (pill_evt && (state_q != FILL) && (SPILL_CNT != '1)) begin
      SPILL_CNT <= SPILL_CNT + CNT_W'(1);
    end
  end
`else
  assign SPILL_CNT = '0;
`endif

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Directed bench for bottle_fill_ctrl: batch fill, swap pause, spill pills, CLEAR/START priority, async reset.
module tb_bottle_fill_ctrl;

  localparam int CNT_W = 8;
`ifdef SPILL_CNT_EN
  localparam bit SPILL_ON = 1'b1;
`else
  localparam bit SPILL_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             RST_N, START, CLEAR, PAUSE, PILL;
  logic [CNT_W-1:0] PER_BOTTLE, BOTTLE_TARGET;
  logic [CNT_W-1:0] PILL_CNT, BOTTLE_CNT, SPILL_CNT;
  logic             BOTTLE_DONE, BUSY, allFull;

  int n_vec     = 0;
  int n_err     = 0;
  int done_seen = 0;

  bottle_fill_ctrl #(.CNT_W(CNT_W), .SWAP_CYCLES(4)) dut (
    .CLK          (clk),
    .RST_N        (RST_N),
    .START        (START),
    .CLEAR        (CLEAR),
    .PAUSE        (PAUSE),
    .PILL         (PILL),
    .PER_BOTTLE   (PER_BOTTLE),
    .BOTTLE_TARGET(BOTTLE_TARGET),
    .PILL_CNT     (PILL_CNT),
    .BOTTLE_CNT   (BOTTLE_CNT),
    .BOTTLE_DONE  (BOTTLE_DONE),
    .BUSY         (BUSY),
    .allFull      (allFull),
    .SPILL_CNT    (SPILL_CNT)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (BOTTLE_DONE === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sp(input int k);
    return SPILL_ON ? k : 0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One pill, then idle so pulses land 10 cycles apart; counts settle 4 cycles after the rise.
  task automatic pill_gap10();
    PILL = 1'b1;
    cyc(1);
    PILL = 1'b0;
    cyc(9);
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; CLEAR = 1'b0; PAUSE = 1'b0; PILL = 1'b0;
    PER_BOTTLE = '0; BOTTLE_TARGET = '0;
    cyc(2);
    chk("rst_pill_cnt", PILL_CNT, 0);
    chk("rst_bottle_cnt", BOTTLE_CNT, 0);
    chk("rst_done", BOTTLE_DONE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_allfull", allFull, 0);
    chk("rst_spill", SPILL_CNT, 0);
    RST_N = 1'b1;
    cyc(2);

    // Batch of 2 bottles x 3 pills; inputs change after START to prove targets are latched.
    PER_BOTTLE = 3; BOTTLE_TARGET = 2; START = 1'b1;
    cyc(1);
    START = 1'b0; PER_BOTTLE = 7; BOTTLE_TARGET = 9;
    chk("busy_after_start", BUSY, 1);
    pill_gap10();
    chk("pill_cnt_1", PILL_CNT, 1);
    pill_gap10();
    chk("pill_cnt_2", PILL_CNT, 2);

    PILL = 1'b1;
    cyc(1);
    PILL = 1'b0;
    cyc(3);
    chk("done_bottle1", BOTTLE_DONE, 1);
    chk("bottle_cnt_1", BOTTLE_CNT, 1);
    chk("pill_cnt_wrap", PILL_CNT, 0);
    chk("busy_swap", BUSY, 1);
    // Hold SWAP for 5 cycles; a pill timed to land in its 9th cycle must not be counted.
    PAUSE = 1'b1;
    cyc(1);
    chk("done_one_cycle", BOTTLE_DONE, 0);
    cyc(4);
    PAUSE = 1'b0;
    PILL = 1'b1;
    cyc(1);
    PILL = 1'b0;
    cyc(10);
    chk("pill_in_swap", PILL_CNT, 0);
    chk("spill_swap", SPILL_CNT, sp(1));
    chk("busy_fill2", BUSY, 1);

    pill_gap10();
    chk("pill_cnt_b2_1", PILL_CNT, 1);
    pill_gap10();
    chk("pill_cnt_b2_2", PILL_CNT, 2);
    PILL = 1'b1;
    cyc(1);
    PILL = 1'b0;
    cyc(2);
    chk("allfull_not_early", allFull, 0);
    cyc(1);
    chk("allfull_rise", allFull, 1);
    chk("done_bottle2", BOTTLE_DONE, 1);
    chk("bottle_cnt_2", BOTTLE_CNT, 2);
    chk("pill_cnt_full", PILL_CNT, 0);
    chk("busy_full", BUSY, 0);
    cyc(6);
    chk("done_pulses", done_seen, 2);

    // FULL ignores pills and START.
    pill_gap10();
    chk("pill_in_full", PILL_CNT, 0);
    chk("spill_full", SPILL_CNT, sp(2));
    PER_BOTTLE = 3; BOTTLE_TARGET = 2; START = 1'b1;
    cyc(1);
    START = 1'b0;
    chk("full_start_ign", allFull, 1);
    chk("full_bottle_hold", BOTTLE_CNT, 2);

    CLEAR = 1'b1;
    cyc(1);
    CLEAR = 1'b0;
    chk("clr_allfull", allFull, 0);
    chk("clr_bottle_cnt", BOTTLE_CNT, 0);
    chk("clr_pill_cnt", PILL_CNT, 0);
    chk("clr_busy", BUSY, 0);
    chk("clr_spill", SPILL_CNT, 0);

    // Rejected STARTs.
    PER_BOTTLE = 0; BOTTLE_TARGET = 2; START = 1'b1;
    cyc(1);
    START = 1'b0;
    chk("start_per0", BUSY, 0);
    PER_BOTTLE = 3; BOTTLE_TARGET = 0; START = 1'b1;
    cyc(1);
    START = 1'b0;
    chk("start_tgt0", BUSY, 0);
    PER_BOTTLE = 3; BOTTLE_TARGET = 2; START = 1'b1; CLEAR = 1'b1;
    cyc(1);
    START = 1'b0; CLEAR = 1'b0;
    chk("start_clear", BUSY, 0);
    cyc(2);
    chk("start_not_queued", BUSY, 0);
    pill_gap10();
    chk("pill_in_idle", PILL_CNT, 0);
    chk("spill_idle", SPILL_CNT, sp(1));

    // New batch after CLEAR, then async reset mid-FILL.
    PER_BOTTLE = 5; BOTTLE_TARGET = 1; START = 1'b1;
    cyc(1);
    START = 1'b0;
    chk("new_batch_busy", BUSY, 1);
    pill_gap10();
    pill_gap10();
    chk("pre_rst_pill_cnt", PILL_CNT, 2);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_pill_cnt", PILL_CNT, 0);
    chk("arst_bottle_cnt", BOTTLE_CNT, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_allfull", allFull, 0);
    chk("arst_spill", SPILL_CNT, 0);
    @(negedge clk);
    RST_N = 1'b1;
    cyc(2);
    chk("post_rst_idle", BUSY, 0);
    PER_BOTTLE = 1; BOTTLE_TARGET = 1; START = 1'b1;
    cyc(1);
    START = 1'b0;
    pill_gap10();
    chk("post_rst_full", allFull, 1);
    chk("post_rst_bottles", BOTTLE_CNT, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
